decryption_regfile_arbiter: RTL and testbench

- Shares the single decryption register-file access port (addr/read/write/wdata to rdata/done/error) between two requesters.
- Requester 0 is the host/config bus; requester 1 is the auto-key loader.
- Per-transaction FSM with round-robin arbitration. Each access is issued as a one-cycle read or write pulse, then the arbiter waits for the register file's registered done/error and returns rdata/error to the winning requester with a one-cycle ack.

---
 rtl/decryption_regfile_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_decryption_regfile_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decryption_regfile_arbiter.sv
// Round-robin arbiter sharing the decryption register-file port between two requesters.
// Optional macro ARB_TIMEOUT_EN adds a WAIT timeout that forces an error completion.
module decryption_regfile_arbiter #(
    parameter int addr_width     = 8,
    parameter int reg_width      = 16,
    parameter int timeout_cycles = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  wr0,
    input  logic                  wr1,
    input  logic [addr_width-1:0] addr0,
    input  logic [addr_width-1:0] addr1,
    input  logic [reg_width-1:0]  wdata0,
    input  logic [reg_width-1:0]  wdata1,
    output logic                  ack0,
    output logic                  ack1,
    output logic [reg_width-1:0]  rdata0,
    output logic [reg_width-1:0]  rdata1,
    output logic                  err0,
    output logic                  err1,
    output logic                  busy,
    output logic [addr_width-1:0] rf_addr,
    output logic                  rf_read,
    output logic                  rf_write,
    output logic [reg_width-1:0]  rf_wdata,
    input  logic [reg_width-1:0]  rf_rdata,
    input  logic                  rf_done,
    input  logic                  rf_error
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic                  gnt_q, gnt_d;
    logic                  last_q, last_d;
    logic                  cur_wr_q, cur_wr_d;
    logic [addr_width-1:0] rf_addr_q, rf_addr_d;
    logic [reg_width-1:0]  rf_wdata_q, rf_wdata_d;
    logic                  rf_read_q, rf_read_d;
    logic                  rf_write_q, rf_write_d;
    logic                  ack0_q, ack0_d;
    logic                  ack1_q, ack1_d;
    logic [reg_width-1:0]  rdata0_q, rdata0_d;
    logic [reg_width-1:0]  rdata1_q, rdata1_d;
    logic                  err0_q, err0_d;
    logic                  err1_q, err1_d;
    logic                  busy_q, busy_d;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = (timeout_cycles > 0);
`endif

    logic                 pick;
    logic                 fin;
    logic [reg_width-1:0] res;
    logic                 res_err;

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_d     = last_q;
        cur_wr_d   = cur_wr_q;
        rf_addr_d  = rf_addr_q;
        rf_wdata_d = rf_wdata_q;
        rf_read_d  = 1'b0;
        rf_write_d = 1'b0;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        err0_d     = err0_q;
        err1_d     = err1_q;
        pick       = 1'b0;
        fin        = 1'b0;
        res        = '0;
        res_err    = 1'b0;
`ifdef ARB_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // contention goes to whoever did not win last time
                    pick       = (req0 && req1) ? ~last_q : req1;
                    gnt_d      = pick;
                    cur_wr_d   = pick ? wr1 : wr0;
                    rf_addr_d  = pick ? addr1 : addr0;
                    rf_wdata_d = pick ? wdata1 : wdata0;
                    rf_write_d = cur_wr_d;
                    rf_read_d  = ~cur_wr_d;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT: begin
                if (rf_done) begin
                    fin     = 1'b1;
                    res     = rf_rdata;
                    res_err = rf_error;
`ifdef ARB_TIMEOUT_EN
                end else if (cnt_q == CW'(timeout_cycles - 1)) begin
                    fin     = 1'b1;
                    res     = '0;
                    res_err = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
                if (fin) begin
                    last_d  = gnt_q;
                    state_d = DONE;
                    if (gnt_q) begin
                        rdata1_d = res;
                        err1_d   = res_err;
                        ack1_d   = 1'b1;
                    end else begin
                        rdata0_d = res;
                        err0_d   = res_err;
                        ack0_d   = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_q      <= 1'b0;
            last_q     <= 1'b1;
            cur_wr_q   <= 1'b0;
            rf_addr_q  <= '0;
            rf_wdata_q <= '0;
            rf_read_q  <= 1'b0;
            rf_write_q <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            err0_q     <= 1'b0;
            err1_q     <= 1'b0;
            busy_q     <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_q     <= last_d;
            cur_wr_q   <= cur_wr_d;
            rf_addr_q  <= rf_addr_d;
            rf_wdata_q <= rf_wdata_d;
            rf_read_q  <= rf_read_d;
            rf_write_q <= rf_write_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            err0_q     <= err0_d;
            err1_q     <= err1_d;
            busy_q     <= busy_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign rdata0   = rdata0_q;
    assign rdata1   = rdata1_q;
    assign err0     = err0_q;
    assign err1     = err1_q;
    assign busy     = busy_q;
    assign rf_addr  = rf_addr_q;
    assign rf_read  = rf_read_q;
    assign rf_write = rf_write_q;
    assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_decryption_regfile_arbiter.sv
// Bench for decryption_regfile_arbiter: register-file stand-in, timing model, directed tests.
// Expectations under ARB_TIMEOUT_EN follow the same macro.
module tb_decryption_regfile_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1, wr0, wr1;
    logic [7:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        ack0, ack1, err0, err1, busy;
    logic [15:0] rdata0, rdata1;
    logic [7:0]  rf_addr;
    logic        rf_read, rf_write;
    logic [15:0] rf_wdata;
    logic [15:0] rf_rdata = 16'h0;
    logic        rf_done = 1'b0;
    logic        rf_error = 1'b0;
    logic        rf_dead;

    int total = 0;
    int bad = 0;
    int ack0_cnt = 0;
    int aq[$];

    decryption_regfile_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
        .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1),
        .rdata0(rdata0), .rdata1(rdata1),
        .err0(err0), .err1(err1), .busy(busy),
        .rf_addr(rf_addr), .rf_read(rf_read), .rf_write(rf_write),
        .rf_wdata(rf_wdata), .rf_rdata(rf_rdata),
        .rf_done(rf_done), .rf_error(rf_error)
    );

    always #5 clk = ~clk;

    function automatic int cyc_now();
        return int'(($time - 5) / 10);
    endfunction

    function automatic bit ok_addr(input logic [7:0] a);
        return a[7:4] == 4'h1;
    endfunction

    function automatic logic [15:0] rst_val(input logic [7:0] a);
        if (a == 8'h12) return 16'hFFFF;
        if (a == 8'h14) return 16'h0002;
        return 16'h0000;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // register-file stand-in: registered done/error, valid window 0x10..0x1F
    logic [15:0] e_mem [256];
    bit          e_wr [256];
    always @(posedge clk) begin
        rf_done <= 1'b0;
        if (!rf_dead && (rf_read || rf_write)) begin
            rf_done  <= 1'b1;
            rf_error <= !ok_addr(rf_addr);
            if (ok_addr(rf_addr)) begin
                if (rf_write) begin
                    e_mem[rf_addr] <= rf_wdata;
                    e_wr[rf_addr]  <= 1'b1;
                end else begin
                    rf_rdata <= e_wr[rf_addr] ? e_mem[rf_addr] : rst_val(rf_addr);
                end
            end
        end
    end

    // transaction-level model: grant cycle, issue cycle, ack cycle, results
    logic [15:0] g_mem [256];
    bit          g_wr [256];
    logic [15:0] g_last = 16'h0;
    int          m_issue, m_ack, m_gnt, m_last;
    bit          m_wr, m_er;
    logic [7:0]  m_addr;
    logic [15:0] m_wdata, m_rd;
    logic [15:0] e_rd0, e_rd1;
    bit          e_er0, e_er1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_issue = -1000;
            m_ack   = -1000;
            m_last  = 1;
            m_gnt   = 0;
            m_wr    = 0;
            m_addr  = 0;
            m_wdata = 0;
            e_rd0   = 0;
            e_rd1   = 0;
            e_er0   = 0;
            e_er1   = 0;
        end else begin
            int k, w;
            k = cyc_now();
            if (k == m_ack) begin
                if (m_gnt == 0) begin
                    e_rd0 = m_rd;
                    e_er0 = m_er;
                end else begin
                    e_rd1 = m_rd;
                    e_er1 = m_er;
                end
            end
            if (k - 1 > m_ack && (req0 || req1)) begin
                w       = (req0 && req1) ? (m_last == 0 ? 1 : 0) : (req1 ? 1 : 0);
                m_last  = w;
                m_gnt   = w;
                m_wr    = (w == 1) ? wr1 : wr0;
                m_addr  = (w == 1) ? addr1 : addr0;
                m_wdata = (w == 1) ? wdata1 : wdata0;
                m_issue = k;
                if (rf_dead) begin
`ifdef ARB_TIMEOUT_EN
                    m_ack = k + TO + 1;
                    m_rd  = 16'h0;
                    m_er  = 1'b1;
`else
                    m_ack = 1 << 30;
`endif
                end else begin
                    m_ack = k + 2;
                    m_er  = !ok_addr(m_addr);
                    m_rd  = g_last;
                    if (ok_addr(m_addr)) begin
                        if (m_wr) begin
                            g_mem[m_addr] = m_wdata;
                            g_wr[m_addr]  = 1'b1;
                        end else begin
                            g_last = g_wr[m_addr] ? g_mem[m_addr] : rst_val(m_addr);
                            m_rd   = g_last;
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        int  k;
        bit  mb, iss;
        k   = cyc_now();
        mb  = (k >= m_issue) && (k <= m_ack);
        iss = (k == m_issue);
        check("busy", busy, mb);
        check("rf_read", rf_read, iss && !m_wr);
        check("rf_write", rf_write, iss && m_wr);
        check("ack0", ack0, k == m_ack && m_gnt == 0);
        check("ack1", ack1, k == m_ack && m_gnt == 1);
        check("rdata0", rdata0, e_rd0);
        check("rdata1", rdata1, e_rd1);
        check("err0", err0, e_er0);
        check("err1", err1, e_er1);
        if (mb) begin
            check("rf_addr", rf_addr, m_addr);
            check("rf_wdata", rf_wdata, m_wdata);
        end
        if (!rst_n) begin
            check("rst_rf_addr", rf_addr, 0);
            check("rst_rf_wdata", rf_wdata, 0);
        end
        if (ack0) begin
            aq.push_back(0);
            ack0_cnt++;
        end
        if (ack1) aq.push_back(1);
    end

    task automatic txn(input int n, input bit w, input logic [7:0] a,
                       input logic [15:0] d, input bit sync, output int lat);
        if (sync) begin
            @(posedge clk);
            #1;
        end
        if (n == 0) begin
            wr0 = w; addr0 = a; wdata0 = d; req0 = 1'b1;
        end else begin
            wr1 = w; addr1 = a; wdata1 = d; req1 = 1'b1;
        end
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((n == 0) ? ack0 : ack1) begin
                lat = i;
                break;
            end
        end
        @(posedge clk);
        #1;
        if (n == 0) req0 = 1'b0;
        else req1 = 1'b0;
    endtask

    initial begin
        int la, lb, n0;
        rst_n = 1'b0;
        req0 = 0; req1 = 0; wr0 = 0; wr1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        rf_dead = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        txn(0, 0, 8'h12, 16'h0, 1, la);
        check("t1_lat", la, 3);
        check("t1_rdata0", rdata0, 16'hFFFF);
        check("t1_err0", err0, 0);

        n0 = ack0_cnt;
        txn(1, 1, 8'h10, 16'h0003, 1, la);
        check("t2_wr_done", la, 3);
        txn(1, 0, 8'h10, 16'h0, 1, la);
        check("t2_rdata1", rdata1, 16'h0003);
        check("t2_err1", err1, 0);
        check("t2_no_ack0", ack0_cnt - n0, 0);

        aq.delete();
        fork
            begin
                int x;
                txn(0, 0, 8'h14, 16'h0, 1, x);
                txn(0, 0, 8'h14, 16'h0, 0, x);
            end
            begin
                int y;
                txn(1, 0, 8'h14, 16'h0, 1, y);
                txn(1, 0, 8'h14, 16'h0, 0, y);
            end
        join
        check("t3_cnt", aq.size(), 4);
        if (aq.size() == 4) begin
            check("t3_g0", aq[0], 0);
            check("t3_g1", aq[1], 1);
            check("t3_g2", aq[2], 0);
            check("t3_g3", aq[3], 1);
        end
        check("t3_rdata0", rdata0, 16'h0002);
        check("t3_rdata1", rdata1, 16'h0002);

        txn(0, 0, 8'h05, 16'h0, 1, la);
        check("t4_err0", err0, 1);
        check("t4_rdata0", rdata0, 16'h0002);

        @(posedge clk);
        #1;
        wr1 = 1; addr1 = 8'h10; wdata1 = 16'h0007; req1 = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        req1 = 1'b0;
        @(negedge clk);
        check("t5_busy", busy, 0);
        check("t5_ack1", ack1, 0);
        check("t5_rf_read", rf_read, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        aq.delete();
        fork
            begin
                int x;
                txn(0, 0, 8'h10, 16'h0, 1, x);
            end
            begin
                int y;
                txn(1, 0, 8'h14, 16'h0, 1, y);
            end
        join
        check("t5_cnt", aq.size(), 2);
        if (aq.size() == 2) begin
            check("t5_first", aq[0], 0);
            check("t5_second", aq[1], 1);
        end
        check("t5_rdata0", rdata0, 16'h0007);

        rf_dead = 1'b1;
`ifdef ARB_TIMEOUT_EN
        txn(0, 0, 8'h12, 16'h0, 1, la);
        check("t6_lat", la, TO + 2);
        check("t6_err0", err0, 1);
        check("t6_rdata0", rdata0, 16'h0);
`else
        @(posedge clk);
        #1;
        wr0 = 0; addr0 = 8'h12; req0 = 1'b1;
        repeat (20) @(negedge clk);
        check("t6_busy_hold", busy, 1);
        check("t6_no_ack", ack0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        req0 = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
`endif
        rf_dead = 1'b0;
        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
